reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Sequential read-out engine for the 32×32 register file. On a start pulse it walks addresses 0–31 through one register-file read port and absorbs the one-cycle synchronous read latency. It delivers each word, tagged with its index, on a valid/ready stream with full backpressure support. It sits between the register file's read port and the debug/display path (LED, seven-segment or UART formatter).

## Interface
- No parameters: the register-file depth (32) and width (32) are fixed.
- CLK  in  1  rising-edge clock, shared with the register file
- RST_N  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle request to begin a dump; ignored while Busy
- SR  out  5  read address; drives the register file's SR1 (or SR2) input
- RdData  in  32  connects to the matching ReadReg output; valid the cycle after SR is presented
- OutData  out  32  register contents
- OutIdx  out  5  register index of OutData
- OutLast  out  1  marks the final word of the dump
- OutValid  out  1  OutData/OutIdx/OutLast are valid
- OutReady  in  1  consumer accepts the word; a handshake occurs when OutValid && OutReady at a rising edge
- Busy  out  1  dump in progress
- Done  out  1  one-cycle pulse after the final handshake

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE: Start=1 moves to RUN, clears the issue counter and sets SR=0.
  - RUN: issues addresses 0..31 in order.
  - DRAIN: entered after address 31 is issued; stays until the output buffer is empty and the final handshake is done, then returns to IDLE with Done=1 for one cycle.
- Read pipeline:
  - An address issued in cycle k (SR=a) returns REG[a] on RdData in cycle k+1.
  - The block writes RdData into a 2-entry output FIFO at the end of cycle k+1.
- Issue credit:
  - A new address is issued in a cycle only if (FIFO occupancy + reads in flight − handshake this cycle) < 2.
  - The FIFO therefore never overflows and no read is ever dropped or repeated.
  - When SR is not advancing, it holds its last value. Re-reads are harmless because unissued RdData is ignored.
- Output stream:
  - FIFO head drives OutData/OutIdx/OutLast.
  - While OutValid=1 and OutReady=0, all output fields stay stable.
  - Words emerge in strictly ascending index order 0..31.
- Coherency: a register-file write to address a in the same cycle that a is issued returns the old value, because the register file's read samples before its write. This is required behaviour, not a bug.
- Start while Busy=1 is ignored and has no side effects. Start in the same cycle as Done is accepted and begins a new dump.
- Reset, asynchronous and mid-operation allowed, forces:
  - state=IDLE, FIFO empty, in-flight cleared
  - SR=0, OutValid=0, OutData=0, OutIdx=0, OutLast=0, Busy=0, Done=0
  - Pending words are discarded.

## Timing
- Start sampled at edge 0. Cycle 1: Busy=1, SR=0. Cycle 3: first OutValid (idx 0). Latency from Start to first word is 3 cycles.
- With OutReady held at 1: one word per cycle. Idx 31 is valid in cycle 34, Done pulses in cycle 35, and Busy falls in cycle 35.
- Busy is high from the cycle after Start through the cycle of the final handshake.
- If OutReady stalls for N cycles, Done slips by exactly N cycles and no word is lost or duplicated.
- After OutReady returns to 1, OutValid stays high every cycle with no bubbles while words remain.

## Configuration
- REG_DUMP_CHKSUM_EN
  - Defined: after word 31, the block emits a 33rd word with OutData = XOR of all 32 emitted words, OutIdx=0 and OutLast=1. Word 31 then has OutLast=0. Done follows the checksum handshake, so with no stalls Done pulses in cycle 36.
  - Undefined: 32 words only, word 31 carries OutLast=1, and no checksum logic is built.

## Test plan
- Preload REG[i]=32'h01010101*i, pulse Start, hold OutReady=1 → 32 words with idx 0..31 and matching data in cycles 3–34, Done in cycle 35, OutLast only on idx 31.
- Random OutReady (50% duty) → identical ordered 32-word sequence. Output fields are stable during every stall. Done occurs only after the 32nd handshake.
- OutReady=0 for 10 cycles after first OutValid → SR advances at most 2 addresses. Word 0 is held stable. The dump completes normally with Done delayed by 10 cycles.
- RegW writes 32'hDEADBEEF to R5 in the same cycle SR=5 → word 5 reports the old value. A second dump reports 32'hDEADBEEF.
- Assert RST_N=0 at word 12 → all outputs 0 immediately. After release, Start yields a full clean dump beginning at idx 0.
- With REG_DUMP_CHKSUM_EN defined, using the first scenario's data → 33rd word = 32'h00000000 (the XOR of i for i=0..31 is 0, replicated across 4 bytes), OutLast=1, Done in cycle 36.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks addresses 0..31 and streams each word with its index.
// Latency: Start to first word 3 cycles, one word per cycle without stalls; Done one cycle after last handshake.
// Backpressure: full valid/ready via a 2-entry FIFO with issue credit; REG_DUMP_CHKSUM_EN appends an XOR word.

module reg_dump_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_vld,
  input  logic [W-1:0]             i_wr_dat,
  input  logic                     i_rd_rdy,
  output logic                     o_rd_vld,
  output logic [W-1:0]             o_rd_dat,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop  = (r_count != '0) && i_rd_rdy;
  assign w_push = i_wr_vld && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_dat;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
endmodule

module reg_dump_reader (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Start,
  output logic [4:0]  SR,
  input  logic [31:0] RdData,
  output logic [31:0] OutData,
  output logic [4:0]  OutIdx,
  output logic        OutLast,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [4:0]  idx;
    logic        last;
  } entry_t;

  localparam int         EW        = $bits(entry_t);
  localparam logic [4:0] LAST_ADDR = 5'd31;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_sr;
  logic          r_infl;
  logic [4:0]    r_infl_idx;
  logic          r_done;
  logic          w_start;
  logic          w_issue;
  logic          w_hs;
  logic          w_final_hs;
  logic          w_wr_vld;
  logic          w_rd_vld;
  logic [1:0]    w_count;
  logic [2:0]    w_credit;
  entry_t        w_wr_ent;
  entry_t        w_head;
  logic [EW-1:0] w_wr_bits;
  logic [EW-1:0] w_head_bits;

  assign w_hs       = w_rd_vld && OutReady;
  assign w_final_hs = w_hs && w_head.last;
  // Slots already committed: buffered words plus the read in flight, minus the one leaving now.
  assign w_credit   = {1'b0, w_count} + {2'b00, r_infl} - {2'b00, w_hs};
  assign w_issue    = (r_state == ST_RUN) && (w_credit < 3'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_nxt = ST_RUN;
          w_start     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_issue && (r_sr == LAST_ADDR)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_final_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_infl     <= 1'b0;
      r_infl_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_infl     <= w_issue;
      r_infl_idx <= r_sr;
      r_done     <= (r_state == ST_DRAIN) && w_final_hs;
      if (w_start) begin
        r_sr <= '0;
      end else if (w_issue && (r_sr != LAST_ADDR)) begin
        r_sr <= r_sr + 5'd1;
      end
    end
  end

`ifdef REG_DUMP_CHKSUM_EN
  logic [31:0] r_chk;
  logic        w_chk_push;

  // The checksum word goes in as word 31 leaves; no read is in flight at that point.
  assign w_chk_push = w_hs && (w_head.idx == LAST_ADDR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_chk <= '0;
    end else if (w_start) begin
      r_chk <= '0;
    end else if (w_hs) begin
      r_chk <= r_chk ^ w_head.dat;
    end
  end

  always_comb begin
    w_wr_ent = '0;
    w_wr_vld = r_infl || w_chk_push;
    if (w_chk_push) begin
      w_wr_ent.dat  = r_chk ^ w_head.dat;
      w_wr_ent.idx  = '0;
      w_wr_ent.last = 1'b1;
    end else begin
      w_wr_ent.dat  = RdData;
      w_wr_ent.idx  = r_infl_idx;
      w_wr_ent.last = 1'b0;
    end
  end
`else
  always_comb begin
    w_wr_ent      = '0;
    w_wr_vld      = r_infl;
    w_wr_ent.dat  = RdData;
    w_wr_ent.idx  = r_infl_idx;
    w_wr_ent.last = (r_infl_idx == LAST_ADDR);
  end
`endif

  assign w_wr_bits = w_wr_ent;
  assign w_head    = entry_t'(w_head_bits);

  reg_dump_fifo #(
    .W     (EW),
    .DEPTH (2)
  ) u_fifo (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_wr_vld (w_wr_vld),
    .i_wr_dat (w_wr_bits),
    .i_rd_rdy (OutReady),
    .o_rd_vld (w_rd_vld),
    .o_rd_dat (w_head_bits),
    .o_count  (w_count)
  );

  assign SR       = r_sr;
  assign OutData  = w_head.dat;
  assign OutIdx   = w_head.idx;
  assign OutLast  = w_head.last;
  assign OutValid = w_rd_vld;
  assign Busy     = (r_state != ST_IDLE);
  assign Done     = r_done;
endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register-file model, directed dumps with random data and OutReady.
module tb_reg_dump_reader;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Start;
  logic [4:0]  SR;
  logic [31:0] RdData;
  logic [31:0] OutData;
  logic [4:0]  OutIdx;
  logic        OutLast;
  logic        OutValid;
  logic        OutReady;
  logic        Busy;
  logic        Done;

`ifdef REG_DUMP_CHKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NWORDS = 32 + EXTRA;

  logic [31:0] rf [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  // Register file: synchronous read samples before the same-edge write lands.
  always @(posedge CLK) begin
    RdData <= rf[SR];
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  reg_dump_reader dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .SR(SR), .RdData(RdData),
    .OutData(OutData), .OutIdx(OutIdx), .OutLast(OutLast), .OutValid(OutValid),
    .OutReady(OutReady), .Busy(Busy), .Done(Done)
  );

  task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  task automatic load_rf(input int kind);
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = (kind == 0) ? 32'(32'h01010101 * i) : $urandom;
    end
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  // mode 0: ready held 1; mode 1: 10-cycle stall from first valid; mode 2: random ready.
  task automatic do_dump(input string tag, input int mode, input int abort_idx, input int wr_idx,
                         input int exp_first, input int exp_done);
    logic [31:0] exp_w [NWORDS];
    logic [4:0]  exp_i [NWORDS];
    logic        exp_l [NWORDS];
    logic [31:0] x = '0;
    logic [38:0] prev = '0;
    int  n = 0, stall = 10, first_c = -1, final_c = -1;
    bit  prev_stall = 0, written = 0, finished = 0;
    for (int i = 0; i < 32; i++) begin
      exp_w[i] = rf[i];
      exp_i[i] = 5'(i);
      exp_l[i] = (EXTRA == 0) && (i == 31);
      x ^= rf[i];
    end
`ifdef REG_DUMP_CHKSUM_EN
    exp_w[32] = x;
    exp_i[32] = 5'd0;
    exp_l[32] = 1'b1;
`endif
    Start = 1'b1;
    for (int c = 1; c <= 400 && !finished; c++) begin
      @(negedge CLK);
      Start = (mode == 2) && (c == 10);
      wr_en = 1'b0;
      if (wr_idx >= 0 && !written && SR == 5'(wr_idx)) begin
        wr_en   = 1'b1;
        wr_addr = 5'(wr_idx);
        wr_data = 32'hDEADBEEF;
        written = 1;
      end
      if (mode == 0) OutReady = 1'b1;
      else if (mode == 1) begin
        if ((first_c >= 0 || OutValid) && stall > 0) begin
          OutReady = 1'b0;
          stall--;
        end else OutReady = 1'b1;
      end else OutReady = 1'($urandom_range(0, 1));

      if (final_c >= 0) begin
        chk(tag, "done_pulse", 32'(Done), 32'd1);
        chk(tag, "busy_fall", 32'(Busy), 32'd0);
        if (exp_done >= 0) chk(tag, "done_cycle", 32'(c), 32'(exp_done));
        finished = 1;
      end else if (abort_idx >= 0 && OutValid && OutIdx == 5'(abort_idx)) begin
        RST_N = 1'b0;
        #1;
        chk(tag, "rst_sr", 32'(SR), 32'd0);
        chk(tag, "rst_valid", 32'(OutValid), 32'd0);
        chk(tag, "rst_data", OutData, 32'd0);
        chk(tag, "rst_idx", 32'(OutIdx), 32'd0);
        chk(tag, "rst_last", 32'(OutLast), 32'd0);
        chk(tag, "rst_busy", 32'(Busy), 32'd0);
        chk(tag, "rst_done", 32'(Done), 32'd0);
        finished = 1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
      end else begin
        chk(tag, "busy", 32'(Busy), 32'd1);
        chk(tag, "no_early_done", 32'(Done), 32'd0);
        if (prev_stall) chk(tag, "stable", 32'({OutValid, OutData, OutIdx, OutLast} == prev), 32'd1);
        if (mode != 2) chk(tag, "valid_no_bubble", 32'(OutValid), 32'(c >= 3));
        if (mode == 1 && !OutReady && OutValid) chk(tag, "sr_hold", 32'(SR <= 5'd2), 32'd1);
        if (OutValid) begin
          if (first_c < 0) begin
            first_c = c;
            if (exp_first >= 0) chk(tag, "first_cycle", 32'(c), 32'(exp_first));
          end
          chk(tag, $sformatf("data%0d", n), OutData, exp_w[n]);
          chk(tag, $sformatf("idx%0d", n), 32'(OutIdx), 32'(exp_i[n]));
          chk(tag, $sformatf("last%0d", n), 32'(OutLast), 32'(exp_l[n]));
          if (OutReady) begin
            n++;
            if (n == NWORDS) final_c = c;
          end
        end
        prev_stall = OutValid && !OutReady;
        prev = {OutValid, OutData, OutIdx, OutLast};
      end
    end
    chk(tag, "completed", 32'(finished), 32'd1);
  endtask

  initial begin
    RST_N = 1'b0; Start = 1'b0; OutReady = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    chk("reset", "sr", 32'(SR), 32'd0);
    chk("reset", "valid", 32'(OutValid), 32'd0);
    chk("reset", "data", OutData, 32'd0);
    chk("reset", "idx", 32'(OutIdx), 32'd0);
    chk("reset", "last", 32'(OutLast), 32'd0);
    chk("reset", "busy", 32'(Busy), 32'd0);
    chk("reset", "done", 32'(Done), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    load_rf(0);
    do_dump("ramp", 0, -1, -1, 3, 35 + EXTRA);
    do_dump("chain_rand", 2, -1, -1, -1, -1);
    repeat (3) @(negedge CLK);
    load_rf(1);
    do_dump("rand", 2, -1, -1, -1, -1);
    repeat (2) @(negedge CLK);
    do_dump("stall", 1, -1, -1, 3, 45 + EXTRA);
    repeat (2) @(negedge CLK);
    do_dump("coh_old", 0, -1, 5, 3, 35 + EXTRA);
    repeat (2) @(negedge CLK);
    do_dump("coh_new", 0, -1, -1, 3, 35 + EXTRA);
    repeat (2) @(negedge CLK);
    do_dump("abort", 0, 12, -1, 3, -1);
    do_dump("post_rst", 0, -1, -1, 3, 35 + EXTRA);
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
